// File: rtl/ysyx_25030081_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ysyx_25030081_ifu_pkg;

   // Fetch sequencing: issue a request, wait for the word, hold it for the core.
   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } ifu_state_e;

   // Sequential fetch stride in bytes.
   localparam int unsigned INST_BYTES = 4;

   // Architectural PC after reset.
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_25030081_ifu_fsm.sv
// Fetch sequencer: tracks which phase the single outstanding fetch is in and
// whether its response has been made stale by a redirect (kill).
module ysyx_25030081_ifu_fsm
   import ysyx_25030081_ifu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       req_fire_i,
   input  logic       rsp_valid_i,
   input  logic       out_fire_i,
   input  logic       redirect_valid_i,
   output ifu_state_e state_o,
   output logic       kill_o
);

   ifu_state_e state_q, state_d;
   logic       kill_q, kill_d;

   // Next-state and kill-flag decision for the current phase.
   always_comb begin
      // NOTE: every output of this block gets a default before the case so no path leaves it unassigned (which would infer a latch).
      state_d = state_q;
      kill_d  = kill_q;
      case (state_q)
         REQ: begin
            if (req_fire_i) begin
               state_d = WAIT;
               // A redirect in the acceptance cycle makes the in-flight word stale.
               kill_d  = redirect_valid_i;
            end
         end
         WAIT: begin
            if (rsp_valid_i) begin
               // Stale or redirected responses are dropped and a new fetch starts.
               kill_d  = 1'b0;
               state_d = (kill_q || redirect_valid_i) ? REQ : HOLD;
            end else if (redirect_valid_i) begin
               kill_d = 1'b1;
            end
         end
         HOLD: begin
            if (out_fire_i || redirect_valid_i) begin
               state_d = REQ;
            end
         end
         default: begin
            state_d = REQ;
            kill_d  = 1'b0;
         end
      endcase
   end

   // State and kill registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= REQ;
         kill_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all registers update from pre-edge values.
         state_q <= state_d;
         kill_q  <= kill_d;
      end
   end

   assign state_o = state_q;
   assign kill_o  = kill_q;

endmodule

// File: rtl/ysyx_25030081_ifu.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time, buffers
// the returned word and hands it to the core, applying next-PC redirects.
module ysyx_25030081_ifu
   import ysyx_25030081_ifu_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
)(
   input  logic                  clk,
   input  logic                  rst,
   output logic                  req_valid,
   input  logic                  req_ready,
   output logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  rsp_valid,
   input  logic [DATA_WIDTH-1:0] rsp_data,
   input  logic                  rsp_err,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_inst,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic                  out_err,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc
);

   ifu_state_e            state;
   logic                  kill;
   logic                  req_fire;
   logic                  out_fire;
   logic                  buf_load;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] inst_q;
   logic [ADDR_WIDTH-1:0] bpc_q;
   logic                  err_q;

   ysyx_25030081_ifu_fsm u_fsm (
      .clk              (clk),
      .rst              (rst),
      .req_fire_i       (req_fire),
      .rsp_valid_i      (rsp_valid),
      .out_fire_i       (out_fire),
      .redirect_valid_i (redirect_valid),
      .state_o          (state),
      .kill_o           (kill)
   );

   // The reset state is REQ, so the request is masked while reset is held.
   assign req_valid = rst && (state == REQ);
   assign req_addr  = pc_q;
   assign req_fire  = req_valid && req_ready;

   assign out_valid = (state == HOLD);
   assign out_fire  = out_valid && out_ready;
   assign out_inst  = inst_q;
   assign out_pc    = bpc_q;
   assign out_err   = err_q;

   // Capture only a live response that is not overtaken by a redirect.
   assign buf_load  = (state == WAIT) && rsp_valid && !kill && !redirect_valid;

   // Next PC: a redirect always wins; otherwise step past a consumed word.
   always_comb begin
      pc_d = pc_q;
      if (redirect_valid) begin
         pc_d = redirect_pc;
      end else if (out_fire) begin
         pc_d = pc_q + ADDR_WIDTH'(INST_BYTES);
      end
   end

   // Architectural PC register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   // Instruction buffer; held stable from capture until the core takes it.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: the buffer is reset because the out_* ports must read zero while reset is asserted.
      if (!rst) begin
         inst_q <= '0;
         bpc_q  <= '0;
         err_q  <= 1'b0;
      end else if (buf_load) begin
         inst_q <= rsp_data;
         bpc_q  <= pc_q;
         err_q  <= rsp_err;
      end
   end

endmodule

// File: tb/tb_ysyx_25030081_ifu.sv
// Bench for the fetch unit: a directed vector table for the called-out
// scenarios, a mid-fetch reset sequence, then randomized traffic checked
// against a slot-based behavioural model.
module tb_ysyx_25030081_ifu;

   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam int          NV     = 25;
   localparam int          NRAND  = 2000;

   typedef struct {
      logic [31:0] rr;   // req_ready
      logic [31:0] rv;   // rsp_valid
      logic [31:0] rd;   // rsp_data
      logic [31:0] re;   // rsp_err
      logic [31:0] orr;  // out_ready
      logic [31:0] rdr;  // redirect_valid
      logic [31:0] rpc;  // redirect_pc
      logic [31:0] eqv;  // expected req_valid
      logic [31:0] eqa;  // expected req_addr (when eqv)
      logic [31:0] eov;  // expected out_valid
      logic [31:0] eoi;  // expected out_inst (when eov)
      logic [31:0] eop;  // expected out_pc (when eov)
      logic [31:0] eoe;  // expected out_err (when eov)
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid;
   logic        req_ready = 1'b0;
   logic [31:0] req_addr;
   logic        rsp_valid = 1'b0;
   logic [31:0] rsp_data = '0;
   logic        rsp_err = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_err;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;

   int checks = 0;
   int errors = 0;

   // Behavioural model: one fetch slot (outstanding/stale) and one hand-off slot.
   bit          m_out, m_stale, m_have, m_err;
   logic [31:0] m_pc, m_inst, m_ipc;
   int          m_cnt;
   bit          pend;

   vec_t vec [NV];

   always #5 clk = ~clk;

   ysyx_25030081_ifu dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_addr       (req_addr),
      .rsp_valid      (rsp_valid),
      .rsp_data       (rsp_data),
      .rsp_err        (rsp_err),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc),
      .out_err        (out_err),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // A response may only arrive while a request is outstanding.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend <= 1'b0;
      end else begin
         if (rsp_valid) check1("rsp_only_when_outstanding", pend, 1'b1);
         pend <= (pend && !rsp_valid) || (req_valid && req_ready);
      end
   end

   task automatic drive(input vec_t v);
      req_ready      = v.rr[0];
      rsp_valid      = v.rv[0];
      rsp_data       = v.rd;
      rsp_err        = v.re[0];
      out_ready      = v.orr[0];
      redirect_valid = v.rdr[0];
      redirect_pc    = v.rpc;
   endtask

   task automatic compare_vec(input int i, input vec_t v);
      check1($sformatf("row%0d req_valid", i), req_valid, v.eqv[0]);
      if (v.eqv[0]) check($sformatf("row%0d req_addr", i), req_addr, v.eqa);
      check1($sformatf("row%0d out_valid", i), out_valid, v.eov[0]);
      if (v.eov[0]) begin
         check($sformatf("row%0d out_inst", i), out_inst, v.eoi);
         check($sformatf("row%0d out_pc", i), out_pc, v.eop);
         check1($sformatf("row%0d out_err", i), out_err, v.eoe[0]);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check1({tag, " req_valid"}, req_valid, 1'b0);
      check1({tag, " out_valid"}, out_valid, 1'b0);
      check({tag, " out_inst"}, out_inst, 32'h0);
      check({tag, " out_pc"}, out_pc, 32'h0);
      check1({tag, " out_err"}, out_err, 1'b0);
   endtask

   task automatic compare_model(input int c);
      bit exp_req;
      exp_req = !m_out && !m_have;
      check1($sformatf("rand%0d req_valid", c), req_valid, exp_req);
      if (exp_req) check($sformatf("rand%0d req_addr", c), req_addr, m_pc);
      check1($sformatf("rand%0d out_valid", c), out_valid, m_have);
      if (m_have) begin
         check($sformatf("rand%0d out_inst", c), out_inst, m_inst);
         check($sformatf("rand%0d out_pc", c), out_pc, m_ipc);
         check1($sformatf("rand%0d out_err", c), out_err, m_err);
      end
   endtask

   // Advance the model by one clock using the inputs driven this cycle.
   task automatic model_step(input vec_t v);
      bit fire, rsp, take;
      fire = !m_out && !m_have && v.rr[0];
      rsp  = v.rv[0] && m_out;
      take = m_have && v.orr[0];
      if (v.rdr[0]) begin
         m_pc   = v.rpc;
         m_have = 1'b0;
         if (fire) begin
            m_out = 1'b1; m_stale = 1'b1; m_cnt = $urandom_range(0, 2);
         end else if (rsp) begin
            m_out = 1'b0; m_stale = 1'b0;
         end else if (m_out) begin
            m_stale = 1'b1;
         end
      end else if (fire) begin
         m_out = 1'b1; m_stale = 1'b0; m_cnt = $urandom_range(0, 2);
      end else if (rsp) begin
         if (!m_stale) begin
            m_have = 1'b1; m_inst = v.rd; m_err = v.re[0]; m_ipc = m_pc;
         end
         m_out = 1'b0; m_stale = 1'b0;
      end else if (take) begin
         m_have = 1'b0;
         m_pc   = m_pc + 32'd4;
      end
   endtask

   initial begin
      vec_t v;
      //            rr rv rd            re or rdr rpc             eqv eqa            eov eoi            eop            eoe
      vec[0]  = '{0, 0, 0,            0, 0, 0,  0,              1,  32'h80000000,  0,  0,             0,             0};
      vec[1]  = '{0, 0, 0,            0, 0, 0,  0,              1,  32'h80000000,  0,  0,             0,             0};
      vec[2]  = '{0, 0, 0,            0, 0, 0,  0,              1,  32'h80000000,  0,  0,             0,             0};
      vec[3]  = '{0, 0, 0,            0, 0, 0,  0,              1,  32'h80000000,  0,  0,             0,             0};
      vec[4]  = '{1, 0, 0,            0, 0, 0,  0,              1,  32'h80000000,  0,  0,             0,             0};
      vec[5]  = '{0, 1, 32'h00000013, 0, 0, 0,  0,              0,  0,             0,  0,             0,             0};
      vec[6]  = '{0, 0, 0,            0, 1, 0,  0,              0,  0,             1,  32'h00000013,  32'h80000000,  0};
      vec[7]  = '{1, 0, 0,            0, 0, 0,  0,              1,  32'h80000004,  0,  0,             0,             0};
      vec[8]  = '{0, 1, 32'hDEADBEEF, 1, 0, 0,  0,              0,  0,             0,  0,             0,             0};
      for (int i = 9; i < 14; i++)
         vec[i] = '{0, 0, 0,          0, 0, 0,  0,              0,  0,             1,  32'hDEADBEEF,  32'h80000004,  1};
      vec[14] = '{0, 0, 0,            0, 1, 1,  32'h80000040,   0,  0,             1,  32'hDEADBEEF,  32'h80000004,  1};
      vec[15] = '{1, 0, 0,            0, 0, 0,  0,              1,  32'h80000040,  0,  0,             0,             0};
      vec[16] = '{0, 0, 0,            0, 0, 1,  32'h80000100,   0,  0,             0,  0,             0,             0};
      vec[17] = '{0, 1, 32'hBAD0BAD0, 0, 0, 0,  0,              0,  0,             0,  0,             0,             0};
      vec[18] = '{1, 0, 0,            0, 0, 0,  0,              1,  32'h80000100,  0,  0,             0,             0};
      vec[19] = '{0, 1, 32'h00100093, 0, 0, 0,  0,              0,  0,             0,  0,             0,             0};
      vec[20] = '{0, 0, 0,            0, 1, 1,  32'hFFFFFFFC,   0,  0,             1,  32'h00100093,  32'h80000100,  0};
      vec[21] = '{1, 0, 0,            0, 0, 0,  0,              1,  32'hFFFFFFFC,  0,  0,             0,             0};
      vec[22] = '{0, 1, 32'h11111111, 0, 0, 0,  0,              0,  0,             0,  0,             0,             0};
      vec[23] = '{0, 0, 0,            0, 1, 0,  0,              0,  0,             1,  32'h11111111,  32'hFFFFFFFC,  0};
      vec[24] = '{1, 0, 0,            0, 0, 0,  0,              1,  32'h00000000,  0,  0,             0,             0};

      // Power-on reset.
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      #1 check_reset_outputs("por");

      // Directed table, starting in the first cycle after release.
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < NV; i++) begin
         #1;
         compare_vec(i, vec[i]);
         drive(vec[i]);
         @(negedge clk);
      end

      // Reset while a fetch is outstanding (the last row was accepted).
      v = '{default: 0};
      drive(v);
      rst = 1'b0;
      #1 check_reset_outputs("rst_in_wait");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check1("post_reset req_valid", req_valid, 1'b1);
      check("post_reset req_addr", req_addr, RST_PC);

      // Randomized traffic against the model.
      m_pc = RST_PC; m_out = 1'b0; m_stale = 1'b0; m_have = 1'b0;
      m_inst = '0; m_ipc = '0; m_err = 1'b0; m_cnt = 0;
      for (int c = 0; c < NRAND; c++) begin
         compare_model(c);
         v     = '{default: 0};
         v.rr  = ($urandom_range(0, 3) != 0) ? 1 : 0;
         v.orr = ($urandom_range(0, 2) != 0) ? 1 : 0;
         v.rdr = ($urandom_range(0, 11) == 0) ? 1 : 0;
         v.rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC : $urandom;
         if (m_out) begin
            if (m_cnt == 0) begin
               v.rv = 1;
               v.rd = $urandom;
               v.re = ($urandom_range(0, 7) == 0) ? 1 : 0;
            end else begin
               m_cnt--;
            end
         end
         drive(v);
         model_step(v);
         @(negedge clk);
         #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ysyx_25030081_ifu.md
# ysyx_25030081_ifu

Instruction fetch unit directly upstream of the single-cycle core, which consumes its `out_inst` as `inst`. It owns the architectural PC, issues one word fetch at a time over a valid/ready request channel to instruction memory, and buffers the returned word. It presents the word to the core with a valid/ready handshake and applies the core's next-PC redirects. At most one request is outstanding; stale responses after a redirect are discarded.

## Interface
- `ADDR_WIDTH`, 32, address/PC width
- `DATA_WIDTH`, 32, instruction width
- `RESET_PC`, 32'h8000_0000, PC after reset

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `req_valid`  out  1  fetch request valid
- `req_ready`  in  1  memory accepts request
- `req_addr`  out  ADDR_WIDTH  fetch address (= PC)
- `rsp_valid`  in  1  response valid, single-cycle pulse, never in the cycle of request acceptance
- `rsp_data`  in  DATA_WIDTH  fetched word
- `rsp_err`  in  1  access fault for this response
- `out_valid`  out  1  instruction available to core
- `out_ready`  in  1  core consumes instruction
- `out_inst`  out  DATA_WIDTH  buffered instruction
- `out_pc`  out  ADDR_WIDTH  PC of `out_inst`
- `out_err`  out  1  buffered word carries access fault
- `redirect_valid`  in  1  core supplies non-sequential next PC
- `redirect_pc`  in  ADDR_WIDTH  redirect target

## Operation
- State `REQ`:
  - `req_valid`=1 and `req_addr`=pc.
  - On accept (`req_valid && req_ready`), go to `WAIT`.
  - Redirect in `REQ`: pc<=`redirect_pc`. If accepted the same cycle, go to `WAIT` with kill=1; otherwise stay in `REQ`.
- State `WAIT`: `req_valid`=0.
  - On `rsp_valid` with kill=0: latch `rsp_data`/`rsp_err`/pc into the buffer and go to `HOLD`.
  - On `rsp_valid` with kill=1: drop the response, clear kill, go to `REQ`.
  - Redirect without `rsp_valid`: pc<=`redirect_pc`, kill<=1, stay in `WAIT`.
  - Redirect with `rsp_valid` the same cycle: drop the response, pc<=`redirect_pc`, kill<=0, go to `REQ`.
- State `HOLD`: `out_valid`=1; buffer stable until handshake.
  - On `out_valid && out_ready`: pc<=`redirect_valid ? redirect_pc : pc+4`, go to `REQ`. A simultaneous redirect is the accepted instruction's next PC.
  - Redirect without handshake: discard the buffer, pc<=`redirect_pc`, go to `REQ`.
- Arithmetic:
  - pc+4 wraps modulo 2^ADDR_WIDTH.
  - `redirect_pc` is used unmodified; alignment faults are the core's job.
- `rsp_valid` outside `WAIT` is ignored and flagged by a bench assertion.

## Timing
- Reset (async assert): state=`REQ`, pc=`RESET_PC`, kill=0, buffer=0. While `rst`=0, `req_valid`=0, `out_valid`=0, `out_inst`=0, `out_pc`=0, `out_err`=0.
  - First request is driven in the first cycle after `rst` deasserts.
- Reset mid-operation: any outstanding request is abandoned. Memory shares `rst`, so no late response arrives.
- Latency:
  - `out_valid` rises the cycle after `rsp_valid`.
  - `req_valid` rises the cycle after the out handshake or redirect.
  - Best case: 3 cycles per instruction (REQ accept, 1-cycle memory, HOLD accept).
- `req_addr` holds stable while `req_valid && !req_ready`, except on redirect.
- Outputs are registered from state/buffer; no combinational path from `rsp_*` to `out_*`.

## Structure
- Package `ysyx_25030081_ifu_pkg`:
  - state enum (`REQ`, `WAIT`, `HOLD`)
  - `INST_BYTES`=4
  - default `RESET_PC`
- FSM, pc, kill flag and buffer stay in one module.
- If split, the natural sub-module is `ysyx_25030081_ifu_fsm` (state + kill).

## Test plan
- Reset release, 1-cycle memory returning 32'h00000013 at 0x80000000, `out_ready`=1 -> `out_valid` in cycle 3, `out_pc`=0x80000000; next `req_addr`=0x80000004.
- `req_ready` low 4 cycles -> `req_addr` stable at 0x80000000, no `out_valid` until accepted.
- Redirect to 0x80000100 in `WAIT` before response -> stale word dropped, next `req_addr`=0x80000100, `out_pc`=0x80000100.
- `out_ready` low 5 cycles in `HOLD` -> `out_inst`/`out_pc` stable; handshake with `redirect_pc`=0x80000040 -> next `req_addr`=0x80000040.
- `rsp_err`=1 -> `out_err`=1 with matching `out_pc`; pc=0xFFFFFFFC accepted -> next `req_addr`=0x00000000.
- `rst` asserted in `WAIT` -> outputs 0 immediately; after release `req_addr`=`RESET_PC`.
